// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. In IDLE a
//   winner is chosen among the pending requests, its operands and opcode are
//   latched, and the latched values are presented to the ALU for exactly one
//   EXEC cycle. The ALU result and zero flag are captured at the end of EXEC
//   and held in RESP until the winning requester takes them.
//
// Configuration:
//   ALU_ARB_RR_EN  defined   -> when both requesters are valid, the one that
//                               was not granted last wins (round-robin).
//                  undefined -> requester 0 always wins a tie (fixed priority).
//
// Parameters:
//   W    operand / result width
//   OPW  ALU opcode width
//
// Ports:
//   clk                      sole clock, rising edge
//   rst_n                    synchronous active-low reset
//   req0_valid, req1_valid   requester has an operation pending
//   req0_ready, req1_ready   operation accepted this cycle (IDLE only)
//   req0_a/b, req1_a/b       operands per requester
//   req0_op, req1_op         ALU opcode per requester, passed through unchanged
//   rsp0_valid, rsp1_valid   result available for that requester
//   rsp0_ready, rsp1_ready   requester consumes its result
//   rsp_result, rsp_zero     shared registered result and zero flag
//   alu_a, alu_b, alu_op     drive the external ALU (zero outside EXEC)
//   alu_result, alu_zero     external ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero,

    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [OPW-1:0] op_q;
    logic           win_q;

    logic           any_req;
    logic           grant_id;
    logic           accept;
    logic           in_exec;
    logic           in_resp;
    logic           win_rsp_ready;

`ifdef ALU_ARB_RR_EN
    // Identity of the requester granted most recently. Resets to 1 so that
    // requester 0 wins the first tie after reset.
    logic           last_grant;

    // Round-robin winner selection. A lone requester always wins; on a tie
    // the requester that was not granted last takes its turn.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end
`else
    // Fixed-priority winner selection: requester 0 wins whenever it is
    // valid, requester 1 only when it is alone.
    always_comb begin
        grant_id = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant_id = 1'b1;
        end
    end
`endif

    // Handshake decode. Acceptance only happens in IDLE and never while reset
    // is asserted, because the state register may still hold anything until
    // the first reset edge.
    always_comb begin
        any_req       = req0_valid | req1_valid;
        accept        = rst_n && (state == IDLE) && any_req;
        req0_ready    = accept && !grant_id;
        req1_ready    = accept &&  grant_id;
        in_exec       = rst_n && (state == EXEC);
        in_resp       = rst_n && (state == RESP);
        win_rsp_ready = win_q ? rsp1_ready : rsp0_ready;
    end

    // ALU drive and response valid decode. The ALU sees the latched operands
    // only in EXEC and all zeros otherwise. The response valid goes only to
    // the latched winner; the other requester never sees it.
    always_comb begin
        alu_a      = in_exec ? a_q  : '0;
        alu_b      = in_exec ? b_q  : '0;
        alu_op     = in_exec ? op_q : '0;
        rsp0_valid = in_resp && !win_q;
        rsp1_valid = in_resp &&  win_q;
    end

    // Main sequencer. IDLE latches the winner's operation, EXEC captures the
    // ALU output, RESP holds the result until the winner's rsp ready is seen.
    // The non-winner's rsp ready and any rsp ready outside RESP are ignored.
    // Reset drops any in-flight operation so no response is ever issued for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            win_q      <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q   <= grant_id ? req1_a  : req0_a;
                        b_q   <= grant_id ? req1_b  : req0_b;
                        op_q  <= grant_id ? req1_op : req0_op;
                        win_q <= grant_id;
`ifdef ALU_ARB_RR_EN
                        last_grant <= grant_id;
`endif
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= RESP;
                end
                RESP: begin
                    if (win_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
